vga_timing_driver: RTL and testbench

- Timing master for the 640x480 VGA output path.
- Generates the pixel scan position (X, Y) and the display_on qualifier consumed by the image renderer.
- Takes back the renderer's registered RGB and drives the DAC/connector pins (R/G/B, HS, VS, BLANK_N, SYNC_N).
- Sync and blank are delayed by a fixed pipeline latency so they line up with the renderer's ROM-plus-register RGB path.

---
 rtl/vga_timing_pkg.sv | 31 +++
 rtl/vga_timing_driver_if.sv | 31 +++
 rtl/vga_sync_delay.sv | 40 ++++
 rtl/vga_timing_driver.sv | 145 ++++++++++++++
 tb/tb_vga_timing_driver.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480@60) and game-state encodings used by
// both the timing driver and the image renderer.
package vga_timing_pkg;

    localparam int H_ACTIVE_C = 32'sd640;
    localparam int H_FRONT_C  = 32'sd16;
    localparam int H_SYNC_C   = 32'sd96;
    localparam int H_BACK_C   = 32'sd48;
    localparam int H_TOTAL_C  = H_ACTIVE_C + H_FRONT_C + H_SYNC_C + H_BACK_C;

    localparam int V_ACTIVE_C = 32'sd480;
    localparam int V_FRONT_C  = 32'sd10;
    localparam int V_SYNC_C   = 32'sd2;
    localparam int V_BACK_C   = 32'sd33;
    localparam int V_TOTAL_C  = V_ACTIVE_C + V_FRONT_C + V_SYNC_C + V_BACK_C;

    typedef enum logic [1:0] {
        START_SCREEN = 2'd0,
        IN_GAME      = 2'd1,
        PAUSE        = 2'd2,
        END_SCREEN   = 2'd3
    } game_state_e;

    // Inclusive window test used for the sync pulse decode.
    function automatic logic in_range(input logic [31:0] v,
                                      input logic [31:0] lo,
                                      input logic [31:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_driver_if.sv
// Bundle between the timing driver, the renderer and the DAC/connector pins.
// master = timing driver; slave = renderer/pin consumer.
interface vga_timing_driver_if;

    logic signed [31:0] X;
    logic signed [31:0] Y;
    logic               display_on;
    logic               frame_start;
    logic               line_start;
    logic        [23:0] RGB;
    logic         [7:0] VGA_R;
    logic         [7:0] VGA_G;
    logic         [7:0] VGA_B;
    logic               VGA_HS;
    logic               VGA_VS;
    logic               VGA_BLANK_N;
    logic               VGA_SYNC_N;

    modport master (
        output X, Y, display_on, frame_start, line_start,
        output VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        input  RGB
    );

    modport slave (
        input  X, Y, display_on, frame_start, line_start,
        input  VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
        output RGB
    );

endinterface

// File: rtl/vga_sync_delay.sv
// W-bit wide, D-deep shift register with asynchronous clear to RST_VAL.
// D = 0 degenerates to a straight wire.
module vga_sync_delay #(
    parameter int           W       = 32'sd1,
    parameter int           D       = 32'sd1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (D == 32'sd0) begin : g_pass
            logic unused_s;
            assign unused_s = clk ^ rst;
            assign dout     = din;
        end else begin : g_shift
            logic [W-1:0] stage_r [D];

            // Shift din toward the tail one stage per clock.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < D; i++) begin
                        stage_r[i] <= RST_VAL;
                    end
                end else begin
                    stage_r[0] <= din;
                    for (int i = 1; i < D; i++) begin
                        stage_r[i] <= stage_r[i-1];
                    end
                end
            end

            assign dout = stage_r[D-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_driver.sv
// VGA timing master: scan counters, registered X/Y/display_on strobes, and
// pin outputs whose sync/blank are delayed to match the renderer RGB latency.
module vga_timing_driver
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE    = H_ACTIVE_C,
    parameter int H_FRONT     = H_FRONT_C,
    parameter int H_SYNC      = H_SYNC_C,
    parameter int H_BACK      = H_BACK_C,
    parameter int V_ACTIVE    = V_ACTIVE_C,
    parameter int V_FRONT     = V_FRONT_C,
    parameter int V_SYNC      = V_SYNC_C,
    parameter int V_BACK      = V_BACK_C,
    parameter bit SYNC_ACTIVE = 1'b0,
    parameter int PIPE_LAT    = 32'sd2
) (
    input  logic                VGA_clk,
    input  logic                rst,
    vga_timing_driver_if.master vga
);

    generate
        if ((PIPE_LAT < 32'sd0) || (PIPE_LAT > 32'sd7)) begin : g_bad_lat
            $error("vga_timing_driver: PIPE_LAT must be in 0..7");
        end
    endgenerate

    localparam logic [31:0] H_LAST_L  = 32'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 32'sd1);
    localparam logic [31:0] V_LAST_L  = 32'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 32'sd1);
    localparam logic [31:0] H_ACT_L   = 32'(H_ACTIVE);
    localparam logic [31:0] V_ACT_L   = 32'(V_ACTIVE);
    localparam logic [31:0] HS_LO_L   = 32'(H_ACTIVE + H_FRONT);
    localparam logic [31:0] HS_HI_L   = 32'(H_ACTIVE + H_FRONT + H_SYNC - 32'sd1);
    localparam logic [31:0] VS_LO_L   = 32'(V_ACTIVE + V_FRONT);
    localparam logic [31:0] VS_HI_L   = 32'(V_ACTIVE + V_FRONT + V_SYNC - 32'sd1);

    logic [31:0]        hcnt_r;
    logic [31:0]        vcnt_r;
    logic               display_on_s;
    logic               hs_raw_s;
    logic               vs_raw_s;
    logic               line_start_s;
    logic               frame_start_s;
    logic signed [31:0] x_r;
    logic signed [31:0] y_r;
    logic               display_on_r;
    logic               line_start_r;
    logic               frame_start_r;
    logic               hs_raw_r;
    logic               vs_raw_r;
    logic [2:0]         tail_s;
    logic [7:0]         r_r;
    logic [7:0]         g_r;
    logic [7:0]         b_r;
    logic               hs_r;
    logic               vs_r;
    logic               blank_n_r;

    // Horizontal/vertical scan counters; vcnt advances only on hcnt wrap.
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            hcnt_r <= 32'd0;
            vcnt_r <= 32'd0;
        end else if (hcnt_r == H_LAST_L) begin
            hcnt_r <= 32'd0;
            vcnt_r <= (vcnt_r == V_LAST_L) ? 32'd0 : vcnt_r + 32'd1;
        end else begin
            hcnt_r <= hcnt_r + 32'd1;
        end
    end

    // Decode qualifiers and raw (active-high) sync from the current counts.
    always_comb begin
        display_on_s  = (hcnt_r < H_ACT_L) && (vcnt_r < V_ACT_L);
        hs_raw_s      = in_range(hcnt_r, HS_LO_L, HS_HI_L);
        vs_raw_s      = in_range(vcnt_r, VS_LO_L, VS_HI_L);
        line_start_s  = (hcnt_r == 32'd0);
        frame_start_s = (hcnt_r == 32'd0) && (vcnt_r == 32'd0);
    end

    // Stage 0: register scan position, qualifiers and raw sync together.
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            x_r           <= 32'sd0;
            y_r           <= 32'sd0;
            display_on_r  <= 1'b0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
            hs_raw_r      <= 1'b0;
            vs_raw_r      <= 1'b0;
        end else begin
            x_r           <= hcnt_r;
            y_r           <= vcnt_r;
            display_on_r  <= display_on_s;
            line_start_r  <= line_start_s;
            frame_start_r <= frame_start_s;
            hs_raw_r      <= hs_raw_s;
            vs_raw_r      <= vs_raw_s;
        end
    end

    vga_sync_delay #(
        .W       (32'sd3),
        .D       (PIPE_LAT),
        .RST_VAL (3'b000)
    ) u_sync_delay (
        .clk  (VGA_clk),
        .rst  (rst),
        .din  ({hs_raw_r, vs_raw_r, display_on_r}),
        .dout (tail_s)
    );

    // Pin register: RGB is forced to zero outside the delayed active window.
    always_ff @(posedge VGA_clk or posedge rst) begin
        if (rst) begin
            r_r       <= 8'd0;
            g_r       <= 8'd0;
            b_r       <= 8'd0;
            hs_r      <= ~SYNC_ACTIVE;
            vs_r      <= ~SYNC_ACTIVE;
            blank_n_r <= 1'b0;
        end else begin
            r_r       <= tail_s[0] ? vga.RGB[23:16] : 8'd0;
            g_r       <= tail_s[0] ? vga.RGB[15:8]  : 8'd0;
            b_r       <= tail_s[0] ? vga.RGB[7:0]   : 8'd0;
            hs_r      <= tail_s[2] ^ ~SYNC_ACTIVE;
            vs_r      <= tail_s[1] ^ ~SYNC_ACTIVE;
            blank_n_r <= tail_s[0];
        end
    end

    assign vga.X           = x_r;
    assign vga.Y           = y_r;
    assign vga.display_on  = display_on_r;
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
    assign vga.VGA_R       = r_r;
    assign vga.VGA_G       = g_r;
    assign vga.VGA_B       = b_r;
    assign vga.VGA_HS      = hs_r;
    assign vga.VGA_VS      = vs_r;
    assign vga.VGA_BLANK_N = blank_n_r;
    assign vga.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_driver.sv
// Directed bench: full 640x480 instance (A, PIPE_LAT=2), a reduced-geometry
// instance (B, 16x12 total, PIPE_LAT=2) for frame-level behaviour and reset,
// and a reduced-geometry PIPE_LAT=0 instance (C).
`timescale 1ns/1ps
module tb_vga_timing_driver;

    logic clk   = 1'b0;
    logic rst_a = 1'b1;
    logic rst_b = 1'b1;
    logic rst_c = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    vga_timing_driver_if ifa ();
    vga_timing_driver_if ifb ();
    vga_timing_driver_if ifc ();

    vga_timing_driver #(.PIPE_LAT(2)) dut_a (
        .VGA_clk (clk),
        .rst     (rst_a),
        .vga     (ifa.master)
    );

    vga_timing_driver #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b0), .PIPE_LAT(2)
    ) dut_b (
        .VGA_clk (clk),
        .rst     (rst_b),
        .vga     (ifb.master)
    );

    vga_timing_driver #(
        .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_ACTIVE(6), .V_FRONT(2), .V_SYNC(2), .V_BACK(2),
        .SYNC_ACTIVE(1'b0), .PIPE_LAT(0)
    ) dut_c (
        .VGA_clk (clk),
        .rst     (rst_c),
        .vga     (ifc.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Renderer model for A: pattern of (X,Y) presented two cycles later.
    initial begin
        logic [23:0] d1;
        logic [23:0] d2;
        d1      = 24'h0;
        d2      = 24'h0;
        ifa.RGB = 24'h0;
        forever begin
            @(negedge clk);
            ifa.RGB = d2;
            d2      = d1;
            d1      = {ifa.X[7:0], ifa.Y[7:0], 8'hA5};
        end
    end

    initial begin
        int n, hi, lo, guard, disp, y0, prev_x;
        int fs_cnt, ls_cnt, fs_bad, ls_bad, max_x, max_y, viol, act_bad, bhi, step_bad;
        logic [7:0] last_r, last_g;
        logic prev_d;

        ifb.RGB = 24'hFFFFFF;
        ifc.RGB = 24'h123456;
        repeat (3) tick();

        // Reset state
        chk("rst_x",       64'(ifa.X), 64'd0);
        chk("rst_y",       64'(ifa.Y), 64'd0);
        chk("rst_disp",    64'(ifa.display_on), 64'd0);
        chk("rst_frame",   64'(ifa.frame_start), 64'd0);
        chk("rst_line",    64'(ifa.line_start), 64'd0);
        chk("rst_rgb",     64'({ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}), 64'd0);
        chk("rst_hs",      64'(ifa.VGA_HS), 64'd1);
        chk("rst_vs",      64'(ifa.VGA_VS), 64'd1);
        chk("rst_blank_n", 64'(ifa.VGA_BLANK_N), 64'd0);
        chk("sync_n",      64'(ifa.VGA_SYNC_N), 64'd0);

        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;
        tick();
        chk("first_x",     64'(ifa.X), 64'd0);
        chk("first_y",     64'(ifa.Y), 64'd0);
        chk("first_frame", 64'(ifa.frame_start), 64'd1);
        chk("first_line",  64'(ifa.line_start), 64'd1);
        chk("first_disp",  64'(ifa.display_on), 64'd1);

        // Pixel (0,0) appears on the pins as BLANK_N first rises, 3 clocks later
        n = 1;
        while (ifa.VGA_BLANK_N !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        chk("blank_rise_lat", 64'(n), 64'd4);
        chk("px00_r", 64'(ifa.VGA_R), 64'h00);
        chk("px00_g", 64'(ifa.VGA_G), 64'h00);
        chk("px00_b", 64'(ifa.VGA_B), 64'hA5);
        chk("px00_x", 64'(ifa.X), 64'd3);

        // Active run of the first line on the pins
        hi = 0;
        last_r = 8'h0;
        last_g = 8'h0;
        while (ifa.VGA_BLANK_N === 1'b1 && hi < 1000) begin
            hi++;
            last_r = ifa.VGA_R;
            last_g = ifa.VGA_G;
            tick();
        end
        chk("line_active_len", 64'(hi), 64'd640);
        chk("last_px_r", 64'(last_r), 64'h7F);
        chk("last_px_g", 64'(last_g), 64'h00);
        chk("blank_fall_x", 64'(ifa.X), 64'd643);
        chk("blank_rgb_a", 64'({ifa.VGA_R, ifa.VGA_G, ifa.VGA_B}), 64'd0);

        // HS falls 3 clocks after X=656 and stays low 96 clocks
        guard = 0;
        while (ifa.X != 32'sd656 && guard < 1000) begin
            tick();
            guard++;
        end
        chk("hs_find_to", 64'(guard < 1000), 64'd1);
        chk("hs_pre0", 64'(ifa.VGA_HS), 64'd1);
        tick();
        tick();
        chk("hs_pre2", 64'(ifa.VGA_HS), 64'd1);
        tick();
        chk("hs_start", 64'(ifa.VGA_HS), 64'd0);
        lo = 0;
        while (ifa.VGA_HS === 1'b0 && lo < 200) begin
            lo++;
            tick();
        end
        chk("hs_width", 64'(lo), 64'd96);

        // Line period, X end value, display_on count per line
        guard  = 0;
        prev_x = ifa.X;
        while (ifa.line_start !== 1'b1 && guard < 1000) begin
            prev_x = ifa.X;
            tick();
            guard++;
        end
        chk("ls_prev_x", 64'(prev_x), 64'd799);
        y0   = ifa.Y;
        n    = 0;
        disp = 0;
        do begin
            if (ifa.display_on === 1'b1) disp++;
            prev_x = ifa.X;
            tick();
            n++;
        end while (ifa.line_start !== 1'b1 && n < 2000);
        chk("line_period", 64'(n), 64'd800);
        chk("line_disp",   64'(disp), 64'd640);
        chk("line_end_x",  64'(prev_x), 64'd799);
        chk("line_y_inc",  64'(ifa.Y), 64'(y0 + 1));

        // B: VS low 2 lines (32 clocks) starting 3 clocks after (0,8)
        guard = 0;
        while (!(ifb.X == 32'sd0 && ifb.Y == 32'sd8) && guard < 400) begin
            tick();
            guard++;
        end
        chk("vs_find_to", 64'(guard < 400), 64'd1);
        chk("vs_pre0", 64'(ifb.VGA_VS), 64'd1);
        tick();
        tick();
        chk("vs_pre2", 64'(ifb.VGA_VS), 64'd1);
        tick();
        chk("vs_start", 64'(ifb.VGA_VS), 64'd0);
        lo = 0;
        while (ifb.VGA_VS === 1'b0 && lo < 100) begin
            lo++;
            tick();
        end
        chk("vs_width", 64'(lo), 64'd32);

        // B: two full frames of statistics with RGB held at FFFFFF
        guard = 0;
        while (ifb.frame_start !== 1'b1 && guard < 400) begin
            tick();
            guard++;
        end
        chk("fs_find_to", 64'(guard < 400), 64'd1);
        fs_cnt = 0; ls_cnt = 0; fs_bad = 0; ls_bad = 0; max_x = 0; max_y = 0;
        viol = 0; act_bad = 0; bhi = 0; disp = 0; step_bad = 0;
        prev_x = 15;
        for (int i = 0; i < 384; i++) begin
            if (ifb.frame_start === 1'b1) begin
                fs_cnt++;
                if ((i % 192) != 0) fs_bad++;
            end
            if (ifb.line_start === 1'b1) begin
                ls_cnt++;
                if ((i % 16) != 0) ls_bad++;
            end
            if (ifb.display_on === 1'b1) disp++;
            if (ifb.X > max_x) max_x = ifb.X;
            if (ifb.Y > max_y) max_y = ifb.Y;
            if (ifb.X != ((prev_x + 1) % 16)) step_bad++;
            prev_x = ifb.X;
            if (ifb.VGA_BLANK_N === 1'b0) begin
                if ({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B} !== 24'h0) viol++;
            end else begin
                bhi++;
                if ({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B} !== 24'hFFFFFF) act_bad++;
            end
            tick();
        end
        chk("b_fs_count",  64'(fs_cnt), 64'd2);
        chk("b_fs_period", 64'(fs_bad), 64'd0);
        chk("b_fs_next",   64'(ifb.frame_start), 64'd1);
        chk("b_ls_count",  64'(ls_cnt), 64'd24);
        chk("b_ls_period", 64'(ls_bad), 64'd0);
        chk("b_disp",      64'(disp), 64'd96);
        chk("b_max_x",     64'(max_x), 64'd15);
        chk("b_max_y",     64'(max_y), 64'd11);
        chk("b_x_step",    64'(step_bad), 64'd0);
        chk("b_blank_rgb", 64'(viol), 64'd0);
        chk("b_active_rgb",64'(act_bad), 64'd0);
        chk("b_blank_hi",  64'(bhi), 64'd96);

        // B: reset mid-frame at (5,4), held 5 clocks
        guard = 0;
        while (!(ifb.X == 32'sd5 && ifb.Y == 32'sd4) && guard < 400) begin
            tick();
            guard++;
        end
        chk("mrst_find_to", 64'(guard < 400), 64'd1);
        chk("mrst_pre_blank", 64'(ifb.VGA_BLANK_N), 64'd1);
        chk("mrst_pre_r",     64'(ifb.VGA_R), 64'hFF);
        rst_b = 1'b1;
        #1;
        chk("mrst_x",       64'(ifb.X), 64'd0);
        chk("mrst_y",       64'(ifb.Y), 64'd0);
        chk("mrst_disp",    64'(ifb.display_on), 64'd0);
        chk("mrst_rgb",     64'({ifb.VGA_R, ifb.VGA_G, ifb.VGA_B}), 64'd0);
        chk("mrst_blank_n", 64'(ifb.VGA_BLANK_N), 64'd0);
        chk("mrst_hs",      64'(ifb.VGA_HS), 64'd1);
        chk("mrst_vs",      64'(ifb.VGA_VS), 64'd1);
        repeat (5) tick();
        rst_b = 1'b0;
        tick();
        chk("rel_x",     64'(ifb.X), 64'd0);
        chk("rel_y",     64'(ifb.Y), 64'd0);
        chk("rel_frame", 64'(ifb.frame_start), 64'd1);
        tick();
        chk("rel_x2",     64'(ifb.X), 64'd1);
        chk("rel_frame2", 64'(ifb.frame_start), 64'd0);

        // C (PIPE_LAT=0): BLANK_N rises one clock after display_on
        guard  = 0;
        prev_d = ifc.display_on;
        tick();
        while (!(ifc.display_on === 1'b1 && prev_d === 1'b0) && guard < 400) begin
            prev_d = ifc.display_on;
            tick();
            guard++;
        end
        chk("c_find_to", 64'(guard < 400), 64'd1);
        chk("c_blank_at_rise", 64'(ifc.VGA_BLANK_N), 64'd0);
        tick();
        chk("c_blank_next", 64'(ifc.VGA_BLANK_N), 64'd1);
        chk("c_r", 64'(ifc.VGA_R), 64'h12);
        chk("c_b", 64'(ifc.VGA_B), 64'h56);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
